// File: rtl/disp_pkg.sv
// Shared display timing constants, pixel word layout and the sideband record
// that travels down the scanout pipe alongside each pixel.
package disp_pkg;

  localparam int H_ACTIVE = 100;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 100;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HC_W = $clog2(H_TOTAL);
  localparam int VC_W = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0] H_ZERO    = HC_W'(0);
  localparam logic [HC_W-1:0] H_ONE     = HC_W'(1);
  localparam logic [HC_W-1:0] H_ACT_END = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_SYNC_LO = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] H_SYNC_HI = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);

  localparam logic [VC_W-1:0] V_ZERO    = VC_W'(0);
  localparam logic [VC_W-1:0] V_ONE     = VC_W'(1);
  localparam logic [VC_W-1:0] V_ACT_END = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_SYNC_LO = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] V_SYNC_HI = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);

  // rgb24 word layout: R in the low byte, B in the high byte
  localparam int RGB_CH_W = 8;
  localparam int RGB_W    = 3 * RGB_CH_W;
  localparam int RGB_R_LO = 0;
  localparam int RGB_G_LO = 8;
  localparam int RGB_B_LO = 16;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic fstart;
  } vid_ctl_t;

  localparam vid_ctl_t VID_CTL_IDLE = '{de: 1'b0, hsync: 1'b0, vsync: 1'b0, fstart: 1'b0};

  function automatic logic [RGB_W-1:0] rgb_pack(input logic [RGB_CH_W-1:0] r,
                                                input logic [RGB_CH_W-1:0] g,
                                                input logic [RGB_CH_W-1:0] b);
    logic [RGB_W-1:0] w;
    w = {RGB_W{1'b0}};
    w[RGB_R_LO +: RGB_CH_W] = r;
    w[RGB_G_LO +: RGB_CH_W] = g;
    w[RGB_B_LO +: RGB_CH_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/disp_timing_gen.sv
// Free-running raster counters with combinational region decode. The decode
// describes the current counter position (the first stage of the scanout pipe).
module disp_timing_gen
  import disp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic origin,
  output logic v_active_next
);

  logic [HC_W-1:0] h_r;
  logic [HC_W-1:0] h_next_s;
  logic [VC_W-1:0] v_r;
  logic [VC_W-1:0] v_next_s;

  // next raster position; v advances only when h wraps
  always_comb begin
    h_next_s = h_r;
    v_next_s = v_r;
    if (h_r == H_LAST) begin
      h_next_s = H_ZERO;
      if (v_r == V_LAST) begin
        v_next_s = V_ZERO;
      end else begin
        v_next_s = v_r + V_ONE;
      end
    end else begin
      h_next_s = h_r + H_ONE;
      v_next_s = v_r;
    end
  end

  // raster counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_r <= H_ZERO;
      v_r <= V_ZERO;
    end else begin
      h_r <= h_next_s;
      v_r <= v_next_s;
    end
  end

  // region decode of the current position
  always_comb begin
    active        = (h_r < H_ACT_END) && (v_r < V_ACT_END);
    hsync         = (h_r >= H_SYNC_LO) && (h_r < H_SYNC_HI);
    vsync         = (v_r >= V_SYNC_LO) && (v_r < V_SYNC_HI);
    origin        = (h_r == H_ZERO) && (v_r == V_ZERO);
    v_active_next = (v_next_s < V_ACT_END);
  end

endmodule

// File: rtl/buf_scanout.sv
// Frame-buffer scanout: fetch stage drives RE0/Addr0, buffer data is aligned
// with its sideband two cycles later, and host-write collisions are flagged.
module buf_scanout
  import disp_pkg::*;
#(
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic              we_mon,
  input  logic              clr_err,
  input  logic [7:0]        buf_r,
  input  logic [7:0]        buf_g,
  input  logic [7:0]        buf_b,
  output logic              RE0,
  output logic [ADDR_W-1:0] Addr0,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              vblank,
  output logic              collision
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic             active_s;
  logic             hsync_s;
  logic             vsync_s;
  logic             origin_s;
  logic             v_act_next_s;
  logic             run_r;
  logic             run_now_s;
  logic             fetch_s;
  vid_ctl_t         ctl_f_s;
  vid_ctl_t         ctl_f_r;
  vid_ctl_t         ctl_b_r;
  vid_ctl_t         ctl_p_r;
  logic             re_r;
  logic [ADDR_W-1:0] addr_r;
  logic             col_b_r;
  logic [RGB_W-1:0] pix_rgb_s;
  logic [RGB_W-1:0] pix_rgb_r;
  logic             collision_s;
  logic             collision_r;
  logic             vblank_r;

  disp_timing_gen u_timing (
    .clk           (clk),
    .reset         (reset),
    .active        (active_s),
    .hsync         (hsync_s),
    .vsync         (vsync_s),
    .origin        (origin_s),
    .v_active_next (v_act_next_s)
  );

  // scan_en only matters at the origin, so a frame is always fetched whole or not at all
  always_comb begin
    run_now_s = run_r;
    if (origin_s) begin
      run_now_s = scan_en;
    end else begin
      run_now_s = run_r;
    end
    fetch_s        = active_s & run_now_s;
    ctl_f_s.de     = fetch_s;
    ctl_f_s.hsync  = hsync_s;
    ctl_f_s.vsync  = vsync_s;
    ctl_f_s.fstart = origin_s & run_now_s;
  end

  // frame-level run flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r <= 1'b0;
    end else begin
      run_r <= run_now_s;
    end
  end

  // fetch stage; fetches within a frame are contiguous so a +1 walks the raster
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      ctl_f_r <= VID_CTL_IDLE;
    end else begin
      re_r    <= fetch_s;
      ctl_f_r <= ctl_f_s;
      if (origin_s) begin
        addr_r <= BASE_ADDR;
      end else if (fetch_s) begin
        addr_r <= addr_r + ADDR_ONE;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // buffer stage: a host write during our read means the buffer ignored it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_b_r <= VID_CTL_IDLE;
      col_b_r <= 1'b0;
    end else begin
      ctl_b_r <= ctl_f_r;
      col_b_r <= re_r & we_mon;
    end
  end

  // pixel data select and sticky collision update (set beats clear)
  always_comb begin
    pix_rgb_s   = {RGB_W{1'b0}};
    collision_s = collision_r;
    if (ctl_b_r.de && !col_b_r) begin
      pix_rgb_s = rgb_pack(buf_r, buf_g, buf_b);
    end else begin
      pix_rgb_s = {RGB_W{1'b0}};
    end
    if (ctl_b_r.de && col_b_r) begin
      collision_s = 1'b1;
    end else if (clr_err) begin
      collision_s = 1'b0;
    end else begin
      collision_s = collision_r;
    end
  end

  // pixel stage and status registers; vblank is computed for the post-edge position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_p_r     <= VID_CTL_IDLE;
      pix_rgb_r   <= {RGB_W{1'b0}};
      collision_r <= 1'b0;
      vblank_r    <= 1'b0;
    end else begin
      ctl_p_r     <= ctl_b_r;
      pix_rgb_r   <= pix_rgb_s;
      collision_r <= collision_s;
      vblank_r    <= ~run_now_s | ~v_act_next_s;
    end
  end

  assign RE0         = re_r;
  assign Addr0       = addr_r;
  assign pix_r       = pix_rgb_r[RGB_R_LO +: RGB_CH_W];
  assign pix_g       = pix_rgb_r[RGB_G_LO +: RGB_CH_W];
  assign pix_b       = pix_rgb_r[RGB_B_LO +: RGB_CH_W];
  assign pix_de      = ctl_p_r.de;
  assign hsync       = ctl_p_r.hsync;
  assign vsync       = ctl_p_r.vsync;
  assign frame_start = ctl_p_r.fstart;
  assign vblank      = vblank_r;
  assign collision   = collision_r;

endmodule
